xu_ly_nut_bam: RTL and testbench

Button front-end that produces the increment/decrement commands consumed by the clock's set-mode editor. Takes the raw active-low `inc_btn`/`dec_btn` pushbuttons (asynchronous, bouncing) and emits clean single-cycle `inc_pulse`/`dec_pulse` strobes, with hold-to-repeat behaviour. Sits between the board pins and the time/date setting logic of `dong_ho_thien_nien_ki`.

---
 rtl/xu_ly_nut_bam.sv | 156 +++++++++++++++
 tb/tb_xu_ly_nut_bam.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xu_ly_nut_bam.sv
// Button front-end: synchronizes, debounces and turns the active-low inc/dec buttons into
// single-cycle command strobes with hold-to-repeat and a both-pressed lockout.
module xu_ly_nut_bam #(
   parameter int unsigned DEBOUNCE_CYC  = 500_000,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_inc_btn,
   input  logic i_dec_btn,
   output logic o_inc_pulse,
   output logic o_dec_pulse,
   output logic o_inc_held,
   output logic o_dec_held
);

   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW   = $clog2(RepMax) + 1;
   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC) + 1;

   localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYC - 1);
   localparam logic [RepW-1:0] RdLast  = RepW'(REPEAT_DELAY - 1);
   localparam logic [RepW-1:0] RpLast  = RepW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {StIdle, StWait, StRepeat, StLock} st_e;

   // Channel index 0 = increment, 1 = decrement.
   logic [1:0]      r_sync1;
   logic [1:0]      r_sync2;
   logic [1:0]      r_vld;
   logic [1:0]      r_armed;
   logic [1:0]      r_db;
   logic [1:0]      r_pulse;
   logic [DbW-1:0]  r_db_cnt [2];
   logic [RepW-1:0] r_rep    [2];
   st_e             r_st     [2];

   logic [1:0]      w_samp;
   logic [1:0]      w_db_d;
   logic [1:0]      w_rise;
   logic [1:0]      w_pulse_d;
   logic            w_both;
   logic            w_none;
   logic [DbW-1:0]  w_db_cnt_d [2];
   logic [RepW-1:0] w_rep_d    [2];
   st_e             w_st_d     [2];

   // Debouncer: accept a level only after DEBOUNCE_CYC consecutive differing samples.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_samp[c]     = ~r_sync2[c];
         w_db_d[c]     = r_db[c];
         w_db_cnt_d[c] = '0;
         if (w_samp[c] != r_db[c]) begin
            if (r_db_cnt[c] == DbLast) begin
               w_db_d[c] = w_samp[c];
            end else begin
               w_db_cnt_d[c] = r_db_cnt[c] + DbW'(1);
            end
         end
      end
   end

   // Press edges only count once the button has been seen released since reset, so a button
   // held through reset stays silent until it is let go and pressed again.
   always_comb begin
      w_both = w_db_d[0] & w_db_d[1];
      w_none = ~w_db_d[0] & ~w_db_d[1];
      for (int c = 0; c < 2; c++) begin
         w_st_d[c]    = r_st[c];
         w_rep_d[c]   = r_rep[c] + RepW'(1);
         w_pulse_d[c] = 1'b0;
         w_rise[c]    = w_db_d[c] & ~r_db[c] & r_armed[c];
         if (w_both) begin
            w_st_d[c]  = StLock;
            w_rep_d[c] = '0;
         end else begin
            unique case (r_st[c])
               StIdle: begin
                  w_rep_d[c] = '0;
                  if (w_rise[c] && i_en) begin
                     w_pulse_d[c] = 1'b1;
                     w_st_d[c]    = StWait;
                  end
               end
               StWait: begin
                  if (!w_db_d[c] || !i_en) begin
                     w_st_d[c]  = StIdle;
                     w_rep_d[c] = '0;
                  end else if (r_rep[c] == RdLast) begin
                     w_pulse_d[c] = 1'b1;
                     w_rep_d[c]   = '0;
                     w_st_d[c]    = StRepeat;
                  end
               end
               StRepeat: begin
                  if (!w_db_d[c] || !i_en) begin
                     w_st_d[c]  = StIdle;
                     w_rep_d[c] = '0;
                  end else if (r_rep[c] == RpLast) begin
                     w_pulse_d[c] = 1'b1;
                     w_rep_d[c]   = '0;
                  end
               end
               StLock: begin
                  w_rep_d[c] = '0;
                  if (w_none) begin
                     w_st_d[c] = StIdle;
                  end
               end
               default: begin
                  w_st_d[c]  = StIdle;
                  w_rep_d[c] = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
         r_vld   <= '0;
         r_armed <= '0;
         r_db    <= '0;
         r_pulse <= '0;
         for (int c = 0; c < 2; c++) begin
            r_db_cnt[c] <= '0;
            r_rep[c]    <= '0;
            r_st[c]     <= StIdle;
         end
      end else begin
         r_sync1 <= {i_dec_btn, i_inc_btn};
         r_sync2 <= r_sync1;
         // r_vld marks when r_sync2 holds real pin samples rather than reset fill.
         r_vld   <= {r_vld[0], 1'b1};
         r_armed <= r_armed | ({2{r_vld[1]}} & r_sync2);
         r_db    <= w_db_d;
         r_pulse <= w_pulse_d;
         for (int c = 0; c < 2; c++) begin
            r_db_cnt[c] <= w_db_cnt_d[c];
            r_rep[c]    <= w_rep_d[c];
            r_st[c]     <= w_st_d[c];
         end
      end
   end

   assign o_inc_pulse = r_pulse[0];
   assign o_dec_pulse = r_pulse[1];
   assign o_inc_held  = r_db[0];
   assign o_dec_held  = r_db[1];

endmodule

// File: tb/tb_xu_ly_nut_bam.sv
// Bench for xu_ly_nut_bam: directed scenarios plus random button/enable/reset traffic, all
// checked every cycle against a history-based reference model.
module tb_xu_ly_nut_bam;

   localparam int unsigned DEB  = 4;
   localparam int unsigned RD   = 20;
   localparam int unsigned RP   = 8;
   localparam int          MAXE = 8192;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic en      = 1'b1;
   logic inc_btn = 1'b1;
   logic dec_btn = 1'b1;
   logic inc_pulse, dec_pulse, inc_held, dec_held;

   int checks = 0;
   int errors = 0;
   int t      = 0;

   // Reference model: raw pin history since reset, derived pressed samples, debounced level,
   // and per-channel "repeating" flag with the absolute cycle of the next due pulse.
   bit raw_h [2][MAXE];
   bit prs_h [2][MAXE];
   int n_since = 0;
   bit m_db       [2];
   bit m_seen_rel [2];
   bit m_active   [2];
   int m_due      [2];
   bit m_locked   = 1'b0;
   bit e_pulse    [2];

   int n_pulse     [2];
   int first_t     [2];
   int held_rise_t [2];
   int held_fall_t [2];
   bit prev_held   [2];
   int inc_times   [$];

   always #5 clk = ~clk;

   xu_ly_nut_bam #(
      .DEBOUNCE_CYC  (DEB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_inc_btn   (inc_btn),
      .i_dec_btn   (dec_btn),
      .o_inc_pulse (inc_pulse),
      .o_dec_pulse (dec_pulse),
      .o_inc_held  (inc_held),
      .o_dec_held  (dec_held)
   );

   task automatic model_edge();
      bit raw [2];
      bit nd  [2];
      raw[0] = inc_btn;
      raw[1] = dec_btn;
      for (int c = 0; c < 2; c++) e_pulse[c] = 1'b0;
      if (rst) begin
         n_since  = 0;
         m_locked = 1'b0;
         for (int c = 0; c < 2; c++) begin
            m_db[c]       = 1'b0;
            m_seen_rel[c] = 1'b0;
            m_active[c]   = 1'b0;
         end
         return;
      end
      if (n_since >= MAXE) begin
         $display("FAIL model_history n_since=%0d limit=%0d", n_since, MAXE);
         $fatal(1, "model history exhausted");
      end
      // Pin level reaches the debouncer two cycles late; level flips after DEB differing samples.
      for (int c = 0; c < 2; c++) begin
         bit stable;
         prs_h[c][n_since] = (n_since >= 2) ? !raw_h[c][n_since-2] : 1'b0;
         nd[c] = m_db[c];
         if (n_since + 1 >= int'(DEB)) begin
            stable = 1'b1;
            for (int j = 0; j < int'(DEB); j++)
               if (prs_h[c][n_since-j] == m_db[c]) stable = 1'b0;
            if (stable) nd[c] = !m_db[c];
         end
      end
      if (nd[0] && nd[1]) begin
         m_locked = 1'b1;
         m_active[0] = 1'b0;
         m_active[1] = 1'b0;
      end else if (m_locked) begin
         if (!nd[0] && !nd[1]) m_locked = 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (m_active[c]) begin
               if (!nd[c] || !en) begin
                  m_active[c] = 1'b0;
               end else if (t == m_due[c]) begin
                  e_pulse[c] = 1'b1;
                  m_due[c]   = t + int'(RP);
               end
            end else if (nd[c] && !m_db[c] && m_seen_rel[c] && en) begin
               e_pulse[c]  = 1'b1;
               m_active[c] = 1'b1;
               m_due[c]    = t + int'(RD);
            end
         end
      end
      for (int c = 0; c < 2; c++) begin
         if (n_since >= 2 && raw_h[c][n_since-2]) m_seen_rel[c] = 1'b1;
         m_db[c] = nd[c];
         raw_h[c][n_since] = raw[c];
      end
      n_since++;
   endtask

   task automatic expect_bit(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic expect_int(string tag, int obs, int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   task automatic clear_stats();
      inc_times.delete();
      for (int c = 0; c < 2; c++) begin
         n_pulse[c]     = 0;
         first_t[c]     = -1;
         held_rise_t[c] = -1;
         held_fall_t[c] = -1;
      end
   endtask

   task automatic step();
      bit ob [2];
      bit oh [2];
      @(posedge clk);
      t++;
      model_edge();
      #1;
      expect_bit("inc_pulse", inc_pulse, e_pulse[0]);
      expect_bit("dec_pulse", dec_pulse, e_pulse[1]);
      expect_bit("inc_held",  inc_held,  m_db[0]);
      expect_bit("dec_held",  dec_held,  m_db[1]);
      ob[0] = inc_pulse;
      ob[1] = dec_pulse;
      oh[0] = inc_held;
      oh[1] = dec_held;
      for (int c = 0; c < 2; c++) begin
         if (ob[c]) begin
            n_pulse[c]++;
            if (first_t[c] < 0) first_t[c] = t;
            if (c == 0) inc_times.push_back(t);
         end
         if (oh[c] && !prev_held[c]) held_rise_t[c] = t;
         if (!oh[c] && prev_held[c]) held_fall_t[c] = t;
         prev_held[c] = oh[c];
      end
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   initial begin
      int k;
      int kr;
      int dur [4];
      bit lvl [4];
      clear_stats();
      prev_held[0] = 1'b0;
      prev_held[1] = 1'b0;

      // 1: single press and release
      rst = 1'b1; en = 1'b1; inc_btn = 1'b1; dec_btn = 1'b1;
      run(2);
      rst = 1'b0;
      expect_bit("t1_reset_inc_held", inc_held, 1'b0);
      run(7);
      clear_stats();
      inc_btn = 1'b0; k = t + 1;
      run(10);
      inc_btn = 1'b1; kr = t + 1;
      run(10);
      expect_int("t1_inc_count", n_pulse[0], 1);
      expect_int("t1_inc_time", first_t[0], k + int'(DEB) + 1);
      expect_int("t1_dec_count", n_pulse[1], 0);
      expect_int("t1_held_rise", held_rise_t[0], k + int'(DEB) + 1);
      expect_int("t1_held_fall", held_fall_t[0], kr + int'(DEB) + 1);

      // 2: bouncing decrement
      clear_stats();
      dur = '{2, 1, 3, 1};
      lvl = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         dec_btn = lvl[i];
         run(dur[i]);
      end
      dec_btn = 1'b0; k = t + 1;
      run(12);
      expect_int("t2_dec_count", n_pulse[1], 1);
      expect_int("t2_dec_time", first_t[1], k + int'(DEB) + 1);
      dec_btn = 1'b1;
      run(10);

      // 3: hold-to-repeat
      clear_stats();
      inc_btn = 1'b0;
      run(60);
      inc_btn = 1'b1;
      run(12);
      expect_int("t3_inc_count", n_pulse[0], 6);
      for (int i = 1; i < inc_times.size() && i < 6; i++)
         expect_int("t3_repeat_offset", inc_times[i] - inc_times[0], int'(RD) + (i - 1) * int'(RP));

      // 4: lockout when both are held
      inc_btn = 1'b0;
      run(30);
      dec_btn = 1'b0;
      run(6);
      clear_stats();
      run(20);
      expect_int("t4_lock_inc", n_pulse[0], 0);
      expect_int("t4_lock_dec", n_pulse[1], 0);
      dec_btn = 1'b1;
      run(20);
      expect_int("t4_half_release_inc", n_pulse[0], 0);
      expect_int("t4_half_release_dec", n_pulse[1], 0);
      inc_btn = 1'b1;
      run(10);
      clear_stats();
      inc_btn = 1'b0;
      run(10);
      expect_int("t4_fresh_inc", n_pulse[0], 1);
      inc_btn = 1'b1;
      run(10);

      // 5: enable gating
      en = 1'b0;
      clear_stats();
      inc_btn = 1'b0;
      run(10);
      expect_int("t5_disabled_count", n_pulse[0], 0);
      expect_bit("t5_disabled_held", inc_held, 1'b1);
      en = 1'b1;
      run(15);
      expect_int("t5_en_rise_count", n_pulse[0], 0);
      inc_btn = 1'b1;
      run(10);
      inc_btn = 1'b0;
      run(10);
      expect_int("t5_repress_count", n_pulse[0], 1);
      inc_btn = 1'b1;
      run(10);

      // 6: reset during repeat
      inc_btn = 1'b0;
      run(35);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_bit("t6_rst_inc_pulse", inc_pulse, 1'b0);
      expect_bit("t6_rst_dec_pulse", dec_pulse, 1'b0);
      expect_bit("t6_rst_inc_held", inc_held, 1'b0);
      expect_bit("t6_rst_dec_held", dec_held, 1'b0);
      clear_stats();
      run(30);
      expect_int("t6_held_no_pulse", n_pulse[0], 0);
      expect_bit("t6_held_after_rst", inc_held, 1'b1);
      inc_btn = 1'b1;
      run(10);
      inc_btn = 1'b0;
      run(10);
      expect_int("t6_repress_count", n_pulse[0], 1);
      inc_btn = 1'b1;
      run(10);

      // Random traffic: bounces, long holds, overlapping presses, enable toggles, resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(24) == 0) inc_btn = ~inc_btn;
         if ($urandom_range(39) == 0) dec_btn = ~dec_btn;
         if ($urandom_range(79) == 0) en = ~en;
         rst = ($urandom_range(499) == 0);
         step();
      end
      rst = 1'b0;
      run(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
